iterative_barrel_shifter: RTL and testbench



---
 rtl/iterative_barrel_shifter.sv | 110 +++++++++++
 tb/tb_iterative_barrel_shifter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_barrel_shifter.sv
// Iterative logical left shifter: one power-of-two stage per clock,
// operand in and result out over valid/ready handshakes.

module singleBarrelShifter #(
  parameter int nBits   = 8,
  parameter int nShifts = 1
) (
  input  logic [nBits-1:0] in_data,
  input  logic             shift,
  output logic [nBits-1:0] out_data
);

  localparam int Dist = 1 << (nShifts - 1);

  assign out_data = shift ? (in_data << Dist) : in_data;

endmodule

module iterative_barrel_shifter #(
  parameter int nBits   = 8,
  parameter int nStages = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [nBits-1:0]   in_data,
  input  logic [nStages-1:0] in_amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [nBits-1:0]   out_data
);

  localparam int KW = (nStages > 1) ? $clog2(nStages) : 1;
  localparam logic [KW-1:0] KLast = KW'(nStages - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [nBits-1:0]   data_r, data_n;
  logic [nStages-1:0] amt_r, amt_n;
  logic [KW-1:0]      k, k_n;
  logic [nBits-1:0]   stage_out [nStages];

  // Stage g shifts by 2^g; only the one picked by k is used each cycle.
  for (genvar g = 0; g < nStages; g++) begin : g_stage
    singleBarrelShifter #(
      .nBits   (nBits),
      .nShifts (g + 1)
    ) u_stage (
      .in_data  (data_r),
      .shift    (amt_r[g]),
      .out_data (stage_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_r <= '0;
      amt_r  <= '0;
      k      <= '0;
    end else begin
      state  <= state_n;
      data_r <= data_n;
      amt_r  <= amt_n;
      k      <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_r;
    amt_n   = amt_r;
    k_n     = k;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_n  = in_data;
          amt_n   = in_amount;
          k_n     = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        data_n = stage_out[k];
        if (k == KLast) begin
          state_n = DONE;
        end else begin
          k_n = k + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_r;

endmodule

// File: tb/tb_iterative_barrel_shifter.sv
// Bench for iterative_barrel_shifter: directed vectors plus a
// random sweep, checked every cycle against a behavioural model.

module tb_iterative_barrel_shifter;

  localparam int NB = 8;
  localparam int NS = 3;
  localparam int MASK = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] in_data = '0;
  logic [NS-1:0] in_amount = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NB-1:0] out_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  iterative_barrel_shifter #(.nBits(NB), .nStages(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: an op is pending for NS cycles of shifting, then waits for
  // out_ready. After j shift cycles the visible data is the operand
  // shifted by the low j bits of the amount.
  bit m_busy = 0;
  int m_cnt = 0;
  int m_op = 0;
  int m_amt = 0;
  int m_cur = 0;
  int acc_n = 0;
  int out_n = 0;
  int sb[$];
  int got[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_cnt = 0;
      m_cur = 0;
      sb.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1;
        m_cnt = 0;
        m_op = int'(in_data);
        m_amt = int'(in_amount);
        m_cur = m_op;
        sb.push_back((m_op << m_amt) & MASK);
        acc_n++;
      end
    end else if (m_cnt < NS) begin
      m_cnt++;
      m_cur = (m_op << (m_amt & ((1 << m_cnt) - 1))) & MASK;
    end else if (out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("sb_result", int'(out_data), sb.pop_front());
      end
      got.push_back(int'(out_data));
      out_n++;
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_busy));
    chk("out_valid", int'(out_valid), int'(m_busy && m_cnt == NS));
    chk("out_data", int'(out_data), m_cur);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input int a);
    int w;
    in_data = NB'(d);
    in_amount = NS'(a);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk("accept_wait", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int d, input int a, input int exp,
                        input int hold);
    int lat;
    accept(d, a);
    lat = 0;
    chk("in_ready_busy", int'(in_ready), 0);
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 3);
    chk("result", int'(out_data), exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), exp);
      chk("hold_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("back_idle", int'(in_ready), 1);
    chk("valid_drop", int'(out_valid), 0);
  endtask

  initial begin
    int t_acc[$];
    int n;
    int cycles;
    bit acc;

    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);

    run_op(8'h01, 5, 8'h20, 4);
    run_op(8'hFF, 7, 8'h80, 0);
    run_op(8'hA5, 0, 8'hA5, 0);

    // Reset asserted on the second shift edge discards the op.
    accept(8'h0F, 3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_ready", int'(in_ready), 1);
    run_op(8'h03, 2, 8'h0C, 0);

    // Back-to-back with both handshakes held high.
    got.delete();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h01;
      in_amount = NS'(1 << i);
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      t_acc.push_back(cyc);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    out_ready = 1'b0;
    chk("b2b_gap1", t_acc[1] - t_acc[0], 5);
    chk("b2b_gap2", t_acc[2] - t_acc[1], 5);
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_r0", got[0], 8'h02);
      chk("b2b_r1", got[1], 8'h04);
      chk("b2b_r2", got[2], 8'h10);
    end

    // Random sweep with stalls on both sides.
    acc_n = 0;
    out_n = 0;
    n = 0;
    cycles = 0;
    in_valid = 1'b0;
    while (n < 1000 && cycles < 40000) begin
      if (!in_valid) begin
        in_data = NB'($urandom);
        in_amount = NS'($urandom);
      end
      if (!in_valid) in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      step();
      cycles++;
      if (acc) begin
        n++;
        in_valid = 1'b0;
      end
    end
    chk("sweep_done", n, 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while (!(in_ready && !out_valid) && cycles < 20) begin
      step();
      cycles++;
    end
    out_ready = 1'b0;
    step();
    chk("drain_idle", int'(in_ready), 1);
    chk("sweep_acc", acc_n, 1000);
    chk("sweep_out", out_n, acc_n);
    chk("sweep_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
